// File: rtl/vga_timing_pkg.sv
// Shared 640x480 @ 60 Hz timing constants, the counter type and a window helper
// for the VGA sync generator and anything that consumes its counts.
package vga_timing_pkg;

   localparam int CNT_W   = 10;
   localparam int MAX_TOT = 1 << CNT_W;
   localparam int DIV_MAX = 16;

   typedef logic [CNT_W-1:0] count_t;

   localparam int HD = 640;
   localparam int HF = 48;
   localparam int HB = 16;
   localparam int HR = 96;
   localparam int VD = 480;
   localparam int VF = 10;
   localparam int VB = 33;
   localparam int VR = 2;

   localparam int H_TOT = HD + HF + HB + HR;
   localparam int V_TOT = VD + VF + VB + VR;

   // Sync pulses sit after the display area plus the right/bottom border.
   localparam int H_SYNC_START = HD + HB;
   localparam int H_SYNC_END   = HD + HB + HR - 1;
   localparam int V_SYNC_START = VD + VF;
   localparam int V_SYNC_END   = VD + VF + VR - 1;

   function automatic logic in_window(count_t v, count_t lo, count_t hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/vga_sync_if.sv
// Timing outputs of vga_sync as seen by the graphics stage downstream.
interface vga_sync_if;
   import vga_timing_pkg::*;

   logic   hsync;
   logic   vsync;
   logic   video_on;
   logic   p_tick;
   logic   frame_tick;
   count_t pixel_x;
   count_t pixel_y;

   modport master (
      output hsync, vsync, video_on, p_tick, frame_tick, pixel_x, pixel_y
   );

   modport slave (
      input hsync, vsync, video_on, p_tick, frame_tick, pixel_x, pixel_y
   );

endinterface

// File: rtl/vga_sync_pixel_tick_gen.sv
// Mod-DIV clock divider; p_tick is high for the one clk where the count is DIV-1,
// so with DIV=1 it is permanently high.
module pixel_tick_gen #(
   parameter int DIV = 2
) (
   input  logic clk,
   input  logic reset,
   output logic p_tick
);
   import vga_timing_pkg::*;

   localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   if (DIV < 1 || DIV > DIV_MAX) begin : g_bad_div
      $error("pixel_tick_gen: DIV out of range 1..16");
   end

   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   assign p_tick = (cnt == LAST);

endmodule

// File: rtl/vga_sync.sv
// VGA timing generator: pixel/line counters plus registered sync and frame pulses,
// all aligned to the same clk so downstream can sample combinationally.
module vga_sync #(
   parameter int DIV = 2,
   parameter int HD  = vga_timing_pkg::HD,
   parameter int HF  = vga_timing_pkg::HF,
   parameter int HB  = vga_timing_pkg::HB,
   parameter int HR  = vga_timing_pkg::HR,
   parameter int VD  = vga_timing_pkg::VD,
   parameter int VF  = vga_timing_pkg::VF,
   parameter int VB  = vga_timing_pkg::VB,
   parameter int VR  = vga_timing_pkg::VR
) (
   input  logic        clk,
   input  logic        reset,
   vga_sync_if.master  vga
);
   import vga_timing_pkg::*;

   localparam int H_LEN = HD + HF + HB + HR;
   localparam int V_LEN = VD + VF + VB + VR;

   if (H_LEN > MAX_TOT || V_LEN > MAX_TOT) begin : g_bad_geom
      $error("vga_sync: H or V total exceeds the 10-bit counter range");
   end

   localparam count_t H_MAX    = count_t'(H_LEN - 1);
   localparam count_t V_MAX    = count_t'(V_LEN - 1);
   localparam count_t HS_START = count_t'(HD + HB);
   localparam count_t HS_END   = count_t'(HD + HB + HR - 1);
   localparam count_t VS_START = count_t'(VD + VF);
   localparam count_t VS_END   = count_t'(VD + VF + VR - 1);
   localparam count_t FT_LINE  = count_t'(VD + 1);
   localparam count_t H_DISP   = count_t'(HD);
   localparam count_t V_DISP   = count_t'(VD);

   logic   tick;
   count_t x, y;
   count_t x_next, y_next;
   logic   hsync_q, vsync_q, frame_q;

   pixel_tick_gen #(.DIV(DIV)) u_tick (
      .clk    (clk),
      .reset  (reset),
      .p_tick (tick)
   );

   // Wrapping on equality with the last count keeps both counters in range
   // for any legal geometry; the corner (H_MAX, V_MAX) wraps to (0,0) in one step.
   always_comb begin
      x_next = x;
      y_next = y;
      if (tick) begin
         if (x == H_MAX) begin
            x_next = '0;
            y_next = (y == V_MAX) ? '0 : y + 10'd1;
         end else begin
            x_next = x + 10'd1;
         end
      end
   end

   // Sync and frame pulses are decoded from the next counts so they change in the
   // same clk as pixel_x/pixel_y; gating frame_tick with tick keeps it one clk wide.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x       <= '0;
         y       <= '0;
         hsync_q <= 1'b0;
         vsync_q <= 1'b0;
         frame_q <= 1'b0;
      end else begin
         x       <= x_next;
         y       <= y_next;
         hsync_q <= in_window(x_next, HS_START, HS_END);
         vsync_q <= in_window(y_next, VS_START, VS_END);
         frame_q <= tick && (x_next == '0) && (y_next == FT_LINE);
      end
   end

   assign vga.pixel_x    = x;
   assign vga.pixel_y    = y;
   assign vga.hsync      = hsync_q;
   assign vga.vsync      = vsync_q;
   assign vga.frame_tick = frame_q;
   assign vga.p_tick     = tick;
   assign vga.video_on   = (x < H_DISP) && (y < V_DISP);

endmodule

// File: tb/tb_vga_sync.sv
// Directed bench for vga_sync: full-size geometry for reset/line/async-reset
// behaviour, shrunken geometries (DIV=2 and DIV=1) for whole-frame behaviour.
module tb_vga_sync;
   import vga_timing_pkg::*;

   typedef struct {
      int div, hd, hb, hr, ht, vd, vf, vr, vt;
   } geom_t;

   localparam geom_t G_DFLT = '{2, HD, HB, HR, H_TOT, VD, VF, VR, V_TOT};
   localparam geom_t G_S2   = '{2, 8, 2, 3, 15, 6, 2, 2, 12};
   localparam geom_t G_S1   = '{1, 8, 2, 3, 15, 6, 2, 2, 12};

   logic clk = 1'b0;
   logic rst;
   logic rst_s;
   int   checks = 0;
   int   errors = 0;
   int   e_d = 0;
   int   e_s = 0;

   always #5 clk = ~clk;

   vga_sync_if vga_d ();
   vga_sync_if vga_s2 ();
   vga_sync_if vga_s1 ();

   vga_sync #(.DIV(2)) dut (
      .clk   (clk),
      .reset (rst),
      .vga   (vga_d.master)
   );

   vga_sync #(.DIV(2), .HD(8), .HF(2), .HB(2), .HR(3),
              .VD(6), .VF(2), .VB(2), .VR(2)) dut_s2 (
      .clk   (clk),
      .reset (rst_s),
      .vga   (vga_s2.master)
   );

   vga_sync #(.DIV(1), .HD(8), .HF(2), .HB(2), .HR(3),
              .VD(6), .VF(2), .VB(2), .VR(2)) dut_s1 (
      .clk   (clk),
      .reset (rst_s),
      .vga   (vga_s1.master)
   );

   function automatic logic [24:0] pack(logic [9:0] x, logic [9:0] y,
                                        logic hs, logic vs, logic von,
                                        logic pt, logic ft);
      return {x, y, hs, vs, von, pt, ft};
   endfunction

   // Expected outputs after e clk edges since reset release.
   function automatic logic [24:0] model(int e, geom_t g);
      int pix, x, y;
      logic hs, vs, von, pt, ft;
      pix = e / g.div;
      x   = pix % g.ht;
      y   = (pix / g.ht) % g.vt;
      pt  = (e % g.div) == g.div - 1;
      hs  = (x >= g.hd + g.hb) && (x <= g.hd + g.hb + g.hr - 1);
      vs  = (y >= g.vd + g.vf) && (y <= g.vd + g.vf + g.vr - 1);
      von = (x < g.hd) && (y < g.vd);
      ft  = (e > 0) && ((e % g.div) == 0) && (x == 0) && (y == g.vd + 1);
      return pack(10'(x), 10'(y), hs, vs, von, pt, ft);
   endfunction

   task automatic run_d(input int target);
      logic [24:0] got, exp;
      bit stop;
      stop = 0;
      while (e_d < target) begin
         @(negedge clk);
         e_d++;
         if (!stop) begin
            got = pack(vga_d.pixel_x, vga_d.pixel_y, vga_d.hsync, vga_d.vsync,
                       vga_d.video_on, vga_d.p_tick, vga_d.frame_tick);
            exp = model(e_d, G_DFLT);
            checks++;
            if (got !== exp) begin
               errors++;
               stop = 1;
               $display("[TB] FAIL dflt_sweep e=%0d got x=%0d y=%0d flags=%b expected x=%0d y=%0d flags=%b",
                        e_d, got[24:15], got[14:5], got[4:0], exp[24:15], exp[14:5], exp[4:0]);
            end
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (5) @(negedge clk);
      checks++;
      if (vga_d.pixel_x !== 10'd0 || vga_d.pixel_y !== 10'd0) begin
         errors++;
         $display("[TB] FAIL reset_counts got x=%0d y=%0d expected 0 0", vga_d.pixel_x, vga_d.pixel_y);
      end
      checks++;
      if ({vga_d.hsync, vga_d.vsync, vga_d.video_on, vga_d.p_tick, vga_d.frame_tick} !== 5'b00100) begin
         errors++;
         $display("[TB] FAIL reset_flags got hs/vs/von/pt/ft=%b expected 00100",
                  {vga_d.hsync, vga_d.vsync, vga_d.video_on, vga_d.p_tick, vga_d.frame_tick});
      end
      rst = 1'b0;
      e_d = 0;
      #1;
      checks++;
      if (vga_d.p_tick !== 1'b0) begin
         errors++;
         $display("[TB] FAIL release_ptick got %b expected 0", vga_d.p_tick);
      end
      @(negedge clk);
      e_d = 1;
      checks++;
      if (vga_d.p_tick !== 1'b1 || vga_d.pixel_x !== 10'd0) begin
         errors++;
         $display("[TB] FAIL first_ptick got pt=%b x=%0d expected pt=1 x=0", vga_d.p_tick, vga_d.pixel_x);
      end
      @(negedge clk);
      e_d = 2;
      checks++;
      if (vga_d.p_tick !== 1'b0 || vga_d.pixel_x !== 10'd1) begin
         errors++;
         $display("[TB] FAIL second_clk got pt=%b x=%0d expected pt=0 x=1", vga_d.p_tick, vga_d.pixel_x);
      end
   endtask

   task automatic test_line();
      run_d(1311);
      checks++;
      if (vga_d.pixel_x !== 10'd655 || vga_d.hsync !== 1'b0) begin
         errors++;
         $display("[TB] FAIL hsync_before got x=%0d hs=%b expected x=655 hs=0", vga_d.pixel_x, vga_d.hsync);
      end
      run_d(1312);
      checks++;
      if (vga_d.pixel_x !== 10'd656 || vga_d.hsync !== 1'b1) begin
         errors++;
         $display("[TB] FAIL hsync_rise got x=%0d hs=%b expected x=656 hs=1", vga_d.pixel_x, vga_d.hsync);
      end
      run_d(1503);
      checks++;
      if (vga_d.pixel_x !== 10'd751 || vga_d.hsync !== 1'b1) begin
         errors++;
         $display("[TB] FAIL hsync_last got x=%0d hs=%b expected x=751 hs=1", vga_d.pixel_x, vga_d.hsync);
      end
      run_d(1504);
      checks++;
      if (vga_d.pixel_x !== 10'd752 || vga_d.hsync !== 1'b0) begin
         errors++;
         $display("[TB] FAIL hsync_fall got x=%0d hs=%b expected x=752 hs=0", vga_d.pixel_x, vga_d.hsync);
      end
      run_d(1599);
      checks++;
      if (vga_d.pixel_x !== 10'd799 || vga_d.pixel_y !== 10'd0) begin
         errors++;
         $display("[TB] FAIL line_end got x=%0d y=%0d expected 799 0", vga_d.pixel_x, vga_d.pixel_y);
      end
      run_d(1600);
      checks++;
      if (vga_d.pixel_x !== 10'd0 || vga_d.pixel_y !== 10'd1) begin
         errors++;
         $display("[TB] FAIL line_wrap got x=%0d y=%0d expected 0 1", vga_d.pixel_x, vga_d.pixel_y);
      end
   endtask

   task automatic test_async_reset();
      run_d(3800);
      checks++;
      if (vga_d.pixel_x !== 10'd300 || vga_d.pixel_y !== 10'd2) begin
         errors++;
         $display("[TB] FAIL pre_reset got x=%0d y=%0d expected 300 2", vga_d.pixel_x, vga_d.pixel_y);
      end
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (vga_d.pixel_x !== 10'd0 || vga_d.pixel_y !== 10'd0 || vga_d.video_on !== 1'b1 ||
          vga_d.p_tick !== 1'b0 || vga_d.hsync !== 1'b0) begin
         errors++;
         $display("[TB] FAIL async_reset got x=%0d y=%0d von=%b pt=%b hs=%b expected 0 0 1 0 0",
                  vga_d.pixel_x, vga_d.pixel_y, vga_d.video_on, vga_d.p_tick, vga_d.hsync);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      e_d = 0;
      run_d(8);
      checks++;
      if (vga_d.pixel_x !== 10'd4 || vga_d.pixel_y !== 10'd0) begin
         errors++;
         $display("[TB] FAIL restart got x=%0d y=%0d expected 4 0", vga_d.pixel_x, vga_d.pixel_y);
      end
   endtask

   // Both small builds run side by side; frame intervals are 15*12*DIV clks.
   task automatic test_small_frames();
      logic [24:0] got, exp;
      bit stop2, stop1;
      int last2, last1, n2, n1;
      stop2 = 0; stop1 = 0;
      last2 = -1; last1 = -1; n2 = 0; n1 = 0;
      rst_s = 1'b1;
      repeat (5) @(negedge clk);
      rst_s = 1'b0;
      e_s = 0;
      while (e_s < 1080) begin
         @(negedge clk);
         e_s++;
         if (!stop2) begin
            got = pack(vga_s2.pixel_x, vga_s2.pixel_y, vga_s2.hsync, vga_s2.vsync,
                       vga_s2.video_on, vga_s2.p_tick, vga_s2.frame_tick);
            exp = model(e_s, G_S2);
            checks++;
            if (got !== exp) begin
               errors++;
               stop2 = 1;
               $display("[TB] FAIL div2_sweep e=%0d got x=%0d y=%0d flags=%b expected x=%0d y=%0d flags=%b",
                        e_s, got[24:15], got[14:5], got[4:0], exp[24:15], exp[14:5], exp[4:0]);
            end
         end
         if (!stop1) begin
            got = pack(vga_s1.pixel_x, vga_s1.pixel_y, vga_s1.hsync, vga_s1.vsync,
                       vga_s1.video_on, vga_s1.p_tick, vga_s1.frame_tick);
            exp = model(e_s, G_S1);
            checks++;
            if (got !== exp) begin
               errors++;
               stop1 = 1;
               $display("[TB] FAIL div1_sweep e=%0d got x=%0d y=%0d flags=%b expected x=%0d y=%0d flags=%b",
                        e_s, got[24:15], got[14:5], got[4:0], exp[24:15], exp[14:5], exp[4:0]);
            end
         end
         if (e_s == 358) begin
            checks++;
            if (vga_s2.pixel_x !== 10'd14 || vga_s2.pixel_y !== 10'd11) begin
               errors++;
               $display("[TB] FAIL corner got x=%0d y=%0d expected 14 11", vga_s2.pixel_x, vga_s2.pixel_y);
            end
         end
         if (e_s == 360) begin
            checks++;
            if (vga_s2.pixel_x !== 10'd0 || vga_s2.pixel_y !== 10'd0) begin
               errors++;
               $display("[TB] FAIL corner_wrap got x=%0d y=%0d expected 0 0", vga_s2.pixel_x, vga_s2.pixel_y);
            end
         end
         if (vga_s2.frame_tick === 1'b1) begin
            n2++;
            if (last2 >= 0) begin
               checks++;
               if (e_s - last2 !== 360) begin
                  errors++;
                  $display("[TB] FAIL div2_period got %0d expected 360", e_s - last2);
               end
            end
            last2 = e_s;
         end
         if (vga_s1.frame_tick === 1'b1) begin
            n1++;
            if (last1 >= 0) begin
               checks++;
               if (e_s - last1 !== 180) begin
                  errors++;
                  $display("[TB] FAIL div1_period got %0d expected 180", e_s - last1);
               end
            end
            last1 = e_s;
         end
      end
      checks++;
      if (n2 !== 3) begin
         errors++;
         $display("[TB] FAIL div2_tick_count got %0d expected 3", n2);
      end
      checks++;
      if (n1 !== 6) begin
         errors++;
         $display("[TB] FAIL div1_tick_count got %0d expected 6", n1);
      end
   endtask

   initial begin
      rst   = 1'b1;
      rst_s = 1'b1;
      $display("[TB] starting vga_sync bench");
      test_reset();
      test_line();
      test_async_reset();
      test_small_frames();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
